// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide engine.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi, lo} accumulator, purely combinational.
// Multiply: conditional add of the multiplicand then shift right; divide: shift left then trial subtract.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_opnd,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_shl;
    logic [XLEN:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
        w_shl  = {i_hi, i_lo[XLEN-1]};
        w_diff = w_shl - {1'b0, i_opnd};
        o_hi   = '0;
        o_lo   = '0;
        if (i_is_div) begin
            // The remainder stays below the divisor, so bit XLEN of the difference is a pure borrow flag.
            if (!w_diff[XLEN]) begin
                o_hi = w_diff[XLEN-1:0];
                o_lo = {i_lo[XLEN-2:0], 1'b1};
            end else begin
                o_hi = w_shl[XLEN-1:0];
                o_lo = {i_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            o_hi = w_sum[XLEN:1];
            o_lo = {w_sum[0], i_lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide beside the ALU: 33 stall cycles for a normal op, 1 for div-by-zero/overflow.
// Holds E via stall_req while computing; result stays presented in DONE while hold_e is asserted.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            hold_e,
    input  logic            kill,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_e r_state, w_state_nxt;
    muldiv_op_e    r_op, w_op;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_hi, r_lo, r_opnd, r_result;
    logic             r_neg;

    logic             w_sign_a, w_sign_b, w_neg, w_div0, w_ovf, w_fast, w_last;
    logic [XLEN-1:0]  w_abs_a, w_abs_b, w_fast_res, w_step_hi, w_step_lo, w_final;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;

    assign w_op     = muldiv_op_e'(funct3);
    assign w_sign_a = (w_op == OP_MULH || w_op == OP_MULHSU || w_op == OP_DIV || w_op == OP_REM) && op_a[XLEN-1];
    assign w_sign_b = (w_op == OP_MULH || w_op == OP_DIV || w_op == OP_REM) && op_b[XLEN-1];
    // Remainder follows the dividend only; quotient and product follow the sign product.
    assign w_neg    = (w_op == OP_REM) ? w_sign_a : (w_sign_a ^ w_sign_b);
    assign w_abs_a  = w_sign_a ? -op_a : op_a;
    assign w_abs_b  = w_sign_b ? -op_b : op_b;
    assign w_div0   = funct3[2] && (op_b == '0);
    assign w_ovf    = (w_op == OP_DIV || w_op == OP_REM) && (op_a == INT_MIN) && (op_b == '1);
    assign w_fast   = w_div0 || w_ovf;
    assign w_fast_res = w_div0 ? (funct3[1] ? op_a : DIV0_QUOT)
                               : (funct3[1] ? '0   : INT_MIN);
    assign w_last   = (r_count == CNT_W'(XLEN-1));

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_is_div (r_op[2]),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_opnd   (r_opnd),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    assign w_prod     = {w_step_hi, w_step_lo};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;

    always_comb begin
        w_final = '0;
        case (r_op)
            OP_MUL:                       w_final = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_final = r_neg ? -w_step_lo : w_step_lo;
            OP_REM, OP_REMU:              w_final = r_neg ? -w_step_hi : w_step_hi;
            default:                      w_final = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (kill) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_state_nxt = w_fast ? DONE : CALC;
                CALC:    if (w_last) w_state_nxt = DONE;
                DONE:    w_state_nxt = hold_e ? DONE : IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        stall_req = ((r_state == IDLE) && start && !kill) || (r_state == CALC);
        done      = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else if (kill) begin
            r_count <= '0;
        end else if (r_state == IDLE && start) begin
            r_op    <= w_op;
            r_neg   <= w_neg;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= funct3[2] ? w_abs_a : w_abs_b;
            r_opnd  <= funct3[2] ? w_abs_b : w_abs_a;
            if (w_fast) r_result <= w_fast_res;
        end else if (r_state == CALC) begin
            r_hi    <= w_step_hi;
            r_lo    <= w_step_lo;
            r_count <= r_count + 1'b1;
            if (w_last) r_result <= w_final;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, fast paths, kill, hold and reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        hold_e;
    logic        kill;
    logic        stall_req;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .hold_e    (hold_e),
        .kill      (kill),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issues one op at the current negedge (DUT must be IDLE), waits for done and
    // reports latency in cycles, the result, and whether stall_req had the required shape.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output bit stall_ok);
        lat      = -1;
        res      = 'x;
        stall_ok = 1'b1;
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        #1;
        if (stall_req !== 1'b1) stall_ok = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            next_cycle();
            start = 1'b0;
            op_a  = 32'hDEAD_BEEF;
            op_b  = 32'h1357_9BDF;
            #1;
            if (done === 1'b1) begin
                lat = n;
                res = result;
                if (stall_req !== 1'b0) stall_ok = 1'b0;
                break;
            end else if (stall_req !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; hold_e = 1'b0;
        funct3 = 3'b000; op_a = '0; op_b = '0;
        next_cycle();
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_req); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++;
        if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", result); end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_mul();
        logic [2:0]  f3  [6] = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b000, 3'b001};
        logic [31:0] a   [6] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000};
        logic [31:0] b   [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h10, 32'h8000_0000};
        logic [31:0] exp [6] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h2345_6780, 32'h4000_0000};
        int lat; logic [31:0] res; bit sok;
        for (int i = 0; i < 6; i++) begin
            issue(f3[i], a[i], b[i], lat, res, sok);
            checks++;
            if (lat != 33 || !sok) begin
                errors++; $display("FAIL mul_timing[%0d] latency %0d stall_ok %0b want 33 1", i, lat, sok);
            end
            checks++;
            if (res !== exp[i]) begin
                errors++; $display("FAIL mul_result[%0d] got %h want %h", i, res, exp[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3  [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b110, 3'b100};
        logic [31:0] a   [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'h8000_0000};
        logic [31:0] b   [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'd2};
        logic [31:0] exp [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'd1, 32'hC000_0000};
        int lat; logic [31:0] res; bit sok;
        for (int i = 0; i < 6; i++) begin
            issue(f3[i], a[i], b[i], lat, res, sok);
            checks++;
            if (lat != 33 || !sok) begin
                errors++; $display("FAIL div_timing[%0d] latency %0d stall_ok %0b want 33 1", i, lat, sok);
            end
            checks++;
            if (res !== exp[i]) begin
                errors++; $display("FAIL div_result[%0d] got %h want %h", i, res, exp[i]);
            end
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]  f3  [5] = '{3'b101, 3'b110, 3'b111, 3'b100, 3'b100};
        logic [31:0] a   [5] = '{32'd55, 32'h8000_0000, 32'h0000_1234, 32'h8000_0000, 32'd5};
        logic [31:0] b   [5] = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'h0, 32'h0000_1234, 32'h8000_0000, 32'hFFFF_FFFF};
        int lat; logic [31:0] res; bit sok;
        for (int i = 0; i < 5; i++) begin
            issue(f3[i], a[i], b[i], lat, res, sok);
            checks++;
            if (lat != 1 || !sok) begin
                errors++; $display("FAIL fast_timing[%0d] latency %0d stall_ok %0b want 1 1", i, lat, sok);
            end
            checks++;
            if (res !== exp[i]) begin
                errors++; $display("FAIL fast_result[%0d] got %h want %h", i, res, exp[i]);
            end
        end
    endtask

    task automatic test_kill();
        int lat; logic [31:0] res; bit sok; bit seen_done;
        seen_done = 1'b0;
        // Kill while IDLE: start must not be accepted.
        funct3 = 3'b100; op_a = 32'd9; op_b = 32'd3; start = 1'b1; kill = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("FAIL kill_idle_stall got %b want 0", stall_req); end
        next_cycle();
        start = 1'b0; kill = 1'b0;
        #1;
        checks++;
        if (stall_req !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL kill_idle_state stall %b done %b want 0 0", stall_req, done);
        end
        next_cycle();
        // Kill a DIV at T+10.
        funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd7; start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            start = 1'b0;
            if (done === 1'b1) seen_done = 1'b1;
        end
        kill = 1'b1;
        next_cycle();
        kill = 1'b0;
        #1;
        checks++;
        if (stall_req !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL kill_calc_state stall %b done %b want 0 0", stall_req, done);
        end
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen_done = 1'b1;
            if (i == 0) next_cycle();
        end
        checks++;
        if (seen_done) begin errors++; $display("FAIL kill_no_done got done=1 want none"); end
        issue(3'b101, 32'd100, 32'd7, lat, res, sok);
        checks++;
        if (lat != 33 || !sok || res !== 32'd14) begin
            errors++; $display("FAIL kill_restart latency %0d stall_ok %0b result %h want 33 1 0000000e", lat, sok, res);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2; logic [31:0] res1, res2; bit sok1, sok2;
        issue(3'b000, 32'd3, 32'd5, lat1, res1, sok1);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL b2b_idle_done got %b want 0", done); end
        issue(3'b101, 32'd50, 32'd5, lat2, res2, sok2);
        checks++;
        if (lat1 != 33 || lat2 != 33 || !sok1 || !sok2) begin
            errors++; $display("FAIL b2b_timing latencies %0d %0d want 33 33", lat1, lat2);
        end
        checks++;
        if (res1 !== 32'd15 || res2 !== 32'd10) begin
            errors++; $display("FAIL b2b_result got %h %h want 0000000f 0000000a", res1, res2);
        end
    endtask

    task automatic test_hold();
        bit got;
        got = 1'b0;
        funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
        for (int n = 0; n < 50; n++) begin
            next_cycle();
            start = 1'b0;
            #1;
            if (done === 1'b1) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL hold_wait got no done within 50 cycles want done"); end
        hold_e = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_cycle();
            if (k == 3) hold_e = 1'b0;
            #1;
            checks++;
            if (done !== 1'b1 || result !== 32'hFFFF_FFFE || stall_req !== 1'b0) begin
                errors++; $display("FAIL hold_cycle[%0d] done %b result %h stall %b want 1 fffffffe 0", k, done, result, stall_req);
            end
        end
        next_cycle();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL hold_release done %b want 0", done); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] res; bit sok;
        funct3 = 3'b100; op_a = 32'd77; op_b = 32'd7; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall_req !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++; $display("FAIL reset_mid stall %b done %b result %h want 0 0 00000000", stall_req, done, result);
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        issue(3'b100, 32'd77, 32'd7, lat, res, sok);
        checks++;
        if (lat != 33 || res !== 32'd11) begin
            errors++; $display("FAIL reset_mid_restart latency %0d result %h want 33 0000000b", lat, res);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_kill();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
